// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution datapath and its control unit.
// Op codes here must stay in step with the ALU control unit.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDSUB = 2'd1,
        ST_MUL_IT = 2'd2,
        ST_DIV_IT = 2'd3
    } alu_state_t;

endpackage

// File: rtl/alu_iter_core.sv
// Shared iterative engine for MUL (shift-add, LSB first) and DIV (restoring, MSB first).
// acc_next is the post-step value, so the caller can register the final result on the last step.
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode_div,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic               run,
    output logic               last,
    output logic [2*WIDTH-1:0] acc_next
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic               mode_q;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_diff;
    logic               rem_ge;

    assign acc_hi = acc[2*WIDTH-1:WIDTH];
    assign acc_lo = acc[WIDTH-1:0];

    // The shifted remainder needs WIDTH+1 bits; once b is subtracted it fits WIDTH again.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
        rem_shift = {acc_hi, acc_lo[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, mcand});
        rem_diff  = rem_shift[WIDTH-1:0] - mcand;
        if (mode_q) begin
            if (rem_ge) begin
                acc_next = {rem_diff, acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc_lo[WIDTH-1:1]};
        end
    end

    assign last = run && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            // MUL keeps the multiplier in the low half; DIV keeps the dividend there.
            acc    <= mode_div ? {{WIDTH{1'b0}}, operand_a} : {{WIDTH{1'b0}}, operand_b};
            mcand  <= mode_div ? operand_b : operand_a;
            mode_q <= mode_div;
            cnt    <= '0;
        end else if (run) begin
            acc <= acc_next;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execution datapath: single-cycle ADD/SUB, eight-step MUL/DIV,
// registered results with a one-cycle valid pulse and a busy level.
//
// state     | meaning
// ST_IDLE   | waiting for load_alu; operands and op latched on accept
// ST_ADDSUB | one-cycle completion for ADD, SUB and DIV by zero
// ST_MUL_IT | shift-add multiply steps in alu_iter_core
// ST_DIV_IT | restoring divide steps in alu_iter_core
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_alu,
    input  logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             div_by_zero,
    output logic             busy,
    output logic             valid
);

    alu_state_t state, state_next;

    logic [WIDTH-1:0]   a_q, b_q;
    logic [1:0]         op_q;
    logic               accept;
    logic               core_start;
    logic               core_run;
    logic               core_last;
    logic [2*WIDTH-1:0] core_acc_next;
    logic [WIDTH:0]     addsub_sum;
    logic [WIDTH:0]     addsub_diff;

    logic [WIDTH-1:0]   lo_next, hi_next;
    logic               carry_next, dbz_next, busy_next, valid_next;

    assign accept     = (state == ST_IDLE) && load_alu;
    assign core_start = accept && ((alu_op == OP_MUL) ||
                                   ((alu_op == OP_DIV) && (operand_b != '0)));
    assign core_run   = (state == ST_MUL_IT) || (state == ST_DIV_IT);

    alu_iter_core #(.WIDTH(WIDTH)) u_iter_core (
        .clk       (clk),
        .reset     (reset),
        .start     (core_start),
        .mode_div  (alu_op[0]),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .run       (core_run),
        .last      (core_last),
        .acc_next  (core_acc_next)
    );

    // MSB of the widened difference is the borrow (a < b).
    assign addsub_sum  = {1'b0, a_q} + {1'b0, b_q};
    assign addsub_diff = {1'b0, a_q} - {1'b0, b_q};

    always_comb begin
        state_next = state;
        lo_next    = result_lo;
        hi_next    = result_hi;
        carry_next = carry;
        dbz_next   = div_by_zero;
        busy_next  = busy;
        valid_next = 1'b0;

        case (state)
            ST_IDLE: begin
                if (load_alu) begin
                    busy_next = 1'b1;
                    case (alu_op)
                        OP_ADD:  state_next = ST_ADDSUB;
                        OP_SUB:  state_next = ST_ADDSUB;
                        OP_MUL:  state_next = ST_MUL_IT;
                        default: state_next = (operand_b == '0) ? ST_ADDSUB : ST_DIV_IT;
                    endcase
                end
            end

            ST_ADDSUB: begin
                valid_next = 1'b1;
                busy_next  = 1'b0;
                state_next = ST_IDLE;
                case (op_q)
                    OP_ADD: begin
                        lo_next    = addsub_sum[WIDTH-1:0];
                        hi_next    = '0;
                        carry_next = addsub_sum[WIDTH];
                        dbz_next   = 1'b0;
                    end
                    OP_SUB: begin
                        lo_next    = addsub_diff[WIDTH-1:0];
                        hi_next    = '0;
                        carry_next = addsub_diff[WIDTH];
                        dbz_next   = 1'b0;
                    end
                    default: begin
                        lo_next    = '1;
                        hi_next    = a_q;
                        carry_next = 1'b0;
                        dbz_next   = 1'b1;
                    end
                endcase
            end

            ST_MUL_IT, ST_DIV_IT: begin
                if (core_last) begin
                    lo_next    = core_acc_next[WIDTH-1:0];
                    hi_next    = core_acc_next[2*WIDTH-1:WIDTH];
                    carry_next = 1'b0;
                    dbz_next   = 1'b0;
                    valid_next = 1'b1;
                    busy_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_lo   <= '0;
            result_hi   <= '0;
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_ADD;
        end else begin
            result_lo   <= lo_next;
            result_hi   <= hi_next;
            carry       <= carry_next;
            div_by_zero <= dbz_next;
            busy        <= busy_next;
            valid       <= valid_next;
            if (accept) begin
                a_q  <= operand_a;
                b_q  <= operand_b;
                op_q <= alu_op;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed table, randomized ops against
// an arithmetic reference model, and hand sequences for busy/held-load/reset cases.
module tb_alu_exec_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_alu;
    logic [1:0] alu_op;
    logic [7:0] operand_a, operand_b;
    logic [7:0] result_lo, result_hi;
    logic       carry, div_by_zero, busy, valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk         (clk),
        .reset       (reset),
        .load_alu    (load_alu),
        .alu_op      (alu_op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .carry       (carry),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .valid       (valid)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] lo;
        logic [7:0] hi;
        logic       c;
        logic       dz;
        int         lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference results straight from unsigned integer arithmetic.
    function automatic void model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] lo, output logic [7:0] hi,
                                  output logic c, output logic dz, output int lat);
        int unsigned ia, ib, r;
        ia = 32'(a);
        ib = 32'(b);
        hi = 8'h00; c = 1'b0; dz = 1'b0; lat = 1;
        case (op)
            2'd0: begin r = ia + ib; lo = 8'(r % 256); c = (r > 255); end
            2'd1: begin r = (ia + 256 - ib) % 256; lo = 8'(r); c = (ia < ib); end
            2'd2: begin r = ia * ib; lo = 8'(r % 256); hi = 8'(r / 256); lat = 8; end
            default: begin
                if (ib == 0) begin
                    lo = 8'hFF; hi = a; dz = 1'b1;
                end else begin
                    lo = 8'(ia / ib); hi = 8'(ia % ib); lat = 8;
                end
            end
        endcase
    endfunction

    task automatic run_op(input string name, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] lo, input logic [7:0] hi,
                          input logic c, input logic dz, input int lat);
        int  n;
        bit  seen;
        bit  busy_drop;
        @(negedge clk);
        load_alu  = 1'b1;
        alu_op    = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        check({name, " busy_at_accept"}, 16'(busy), 16'd1);
        @(negedge clk);
        load_alu  = 1'b0;
        alu_op    = 2'($urandom_range(0, 3));
        operand_a = 8'($urandom);
        operand_b = 8'($urandom);
        n = 0; seen = 1'b0; busy_drop = 1'b0;
        while (!seen && n < 20) begin
            n++;
            @(posedge clk);
            #1;
            if (valid) seen = 1'b1;
            else if (!busy) busy_drop = 1'b1;
        end
        check({name, " latency"}, 16'(n), 16'(lat));
        check({name, " busy_held"}, 16'(busy_drop), 16'd0);
        check({name, " result"}, {result_hi, result_lo}, {hi, lo});
        check({name, " carry_dbz"}, {14'd0, carry, div_by_zero}, {14'd0, c, dz});
        check({name, " busy_after"}, 16'(busy), 16'd0);
        @(posedge clk);
        #1;
        check({name, " valid_pulse"}, 16'(valid), 16'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] op;
        logic [7:0] a, b, lo, hi;
        logic       c, dz;
        int         lat, n;

        vecs[0] = '{2'd0, 8'd200, 8'd100, 8'h2C, 8'h00, 1'b1, 1'b0, 1};
        vecs[1] = '{2'd1, 8'd5,   8'd10,  8'hFB, 8'h00, 1'b1, 1'b0, 1};
        vecs[2] = '{2'd2, 8'd255, 8'd255, 8'h01, 8'hFE, 1'b0, 1'b0, 8};
        vecs[3] = '{2'd2, 8'd0,   8'd77,  8'h00, 8'h00, 1'b0, 1'b0, 8};
        vecs[4] = '{2'd3, 8'd200, 8'd7,   8'h1C, 8'h04, 1'b0, 1'b0, 8};
        vecs[5] = '{2'd3, 8'd200, 8'd0,   8'hFF, 8'hC8, 1'b0, 1'b1, 1};
        vecs[6] = '{2'd0, 8'd255, 8'd1,   8'h00, 8'h00, 1'b1, 1'b0, 1};
        vecs[7] = '{2'd1, 8'd10,  8'd10,  8'h00, 8'h00, 1'b0, 1'b0, 1};
        vecs[8] = '{2'd3, 8'd5,   8'd9,   8'h00, 8'h05, 1'b0, 1'b0, 8};
        vecs[9] = '{2'd2, 8'd16,  8'd16,  8'h00, 8'h01, 1'b0, 1'b0, 8};

        reset = 1'b0; load_alu = 1'b0; alu_op = 2'd0; operand_a = 8'd0; operand_b = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {result_hi, result_lo}, 16'h0000);
        check("reset_flags", {12'd0, carry, div_by_zero, busy, valid}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (4) begin @(posedge clk); #1; if (valid || busy) n++; end
        check("post_reset_idle", 16'(n), 16'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("table%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].lo, vecs[i].hi, vecs[i].c, vecs[i].dz, vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = (i % 5 == 0) ? 8'd0 : 8'($urandom);
            model(op, a, b, lo, hi, c, dz, lat);
            run_op($sformatf("rand%0d", i), op, a, b, lo, hi, c, dz, lat);
        end

        // ADD pulse at E3 during a MUL must be dropped, not queued.
        @(negedge clk);
        load_alu = 1'b1; alu_op = 2'd2; operand_a = 8'd255; operand_b = 8'd3;
        @(posedge clk);
        @(negedge clk);
        load_alu = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        load_alu = 1'b1; alu_op = 2'd0; operand_a = 8'd1; operand_b = 8'd1;
        @(posedge clk);
        @(negedge clk);
        load_alu = 1'b0;
        n = 3;
        while (n < 20) begin
            n++;
            @(posedge clk);
            #1;
            if (valid) break;
        end
        check("busy_ign latency", 16'(n), 16'd8);
        check("busy_ign result", {result_hi, result_lo}, 16'h02FD);
        n = 0;
        repeat (5) begin @(posedge clk); #1; if (valid || busy) n++; end
        check("busy_ign no_queue", 16'(n), 16'd0);

        // Held load: a new op is accepted on each IDLE edge.
        @(negedge clk);
        load_alu = 1'b1; alu_op = 2'd0; operand_a = 8'd1; operand_b = 8'd2;
        @(posedge clk);
        @(negedge clk);
        alu_op = 2'd1; operand_a = 8'd9; operand_b = 8'd4;
        @(posedge clk);
        #1;
        check("held first", {7'd0, valid, result_lo}, {7'd0, 1'b1, 8'd3});
        @(posedge clk);
        #1;
        check("held accept", {14'd0, busy, valid}, 16'd2);
        @(negedge clk);
        load_alu = 1'b0;
        @(posedge clk);
        #1;
        check("held second", {6'd0, valid, carry, result_lo}, {6'd0, 1'b1, 1'b0, 8'd5});

        // Reset at E4 of a DIV discards everything.
        @(negedge clk);
        load_alu = 1'b1; alu_op = 2'd3; operand_a = 8'd200; operand_b = 8'd7;
        @(posedge clk);
        @(negedge clk);
        load_alu = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midreset outputs", {result_hi, result_lo}, 16'h0000);
        check("midreset flags", {12'd0, carry, div_by_zero, busy, valid}, 16'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        repeat (12) begin @(posedge clk); #1; if (valid || busy) n++; end
        check("midreset no_valid", 16'(n), 16'd0);
        check("midreset hold", {result_hi, result_lo}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
